// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer putting two requesters' read/write commands onto
// a single-port RAM; owns wr_en and the shared data-bus drive timing.
module ram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p1_req,
  input  logic                  p0_we,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p0_gnt,
  output logic                  p1_gnt,
  output logic                  p0_rvalid,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_en,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);
  localparam int NP = 2;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                         state;
  logic                           last;
  logic                           cmd_id;
  logic [DATA_WIDTH-1:0]          cmd_wdata;
  logic [NP-1:0]                  req, gnt, rvalid_q;
  logic [NP-1:0][DATA_WIDTH-1:0]  rdata_q;
  req_t [NP-1:0]                  preq;
  logic                           sel;

  assign req     = {p1_req, p0_req};
  assign preq[0] = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
  assign preq[1] = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};

  // Under contention the port that did not win last time goes next.
  always_comb begin
    sel = (&req) ? ~last : req[1];
    gnt = '0;
    if (rst_n && state == IDLE && |req) gnt[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      cmd_id    <= 1'b0;
      cmd_wdata <= '0;
      ram_addr  <= '0;
      ram_wr_en <= 1'b0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
    end else begin
      rvalid_q <= '0;
      case (state)
        IDLE: if (|gnt) begin
          last      <= sel;
          cmd_id    <= sel;
          cmd_wdata <= preq[sel].wdata;
          ram_addr  <= preq[sel].addr;
          ram_wr_en <= preq[sel].we;
          state     <= preq[sel].we ? WRITE : READ;
        end
        WRITE: begin
          ram_wr_en <= 1'b0;
          state     <= IDLE;
        end
        READ: begin
          rdata_q[cmd_id]  <= ram_data;
          rvalid_q[cmd_id] <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Drive enable is the wr_en flop itself, so the bus can never be double-driven.
  assign ram_data  = ram_wr_en ? cmd_wdata : {DATA_WIDTH{1'bz}};

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_rdata  = rdata_q[0];
  assign p1_rdata  = rdata_q[1];
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer for the single-port RAM (`clk`, `addr`, bidirectional `data`, `wr_en`). It accepts read and write commands from two independent requesters and serialises them onto the RAM's single address/data bus. It owns the `wr_en` and bus-drive timing so the shared `data` line never has two drivers. It sits between the RAM instance and its two client blocks.

## Interface

**Parameters**

- `DATA_WIDTH`, 16, RAM word width.
- `ADDR_WIDTH`, 4, RAM address width (depth `2**ADDR_WIDTH`).

**Ports**

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `p0_req`, `p1_req`  in  1  command request; held until granted.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read; stable while `req` is high.
- `p0_addr`, `p1_addr`  in  `ADDR_WIDTH`  command address.
- `p0_wdata`, `p1_wdata`  in  `DATA_WIDTH`  write data.
- `p0_gnt`, `p1_gnt`  out  1  one-cycle accept strobe.
- `p0_rvalid`, `p1_rvalid`  out  1  one-cycle read-data-valid strobe.
- `p0_rdata`, `p1_rdata`  out  `DATA_WIDTH`  read data; holds until that port's next read completes.
- `ram_addr`  out  `ADDR_WIDTH`  to RAM `addr`.
- `ram_wr_en`  out  1  to RAM `wr_en`.
- `ram_data`  inout  `DATA_WIDTH`  to RAM `data`.
  - Driven by the arbiter only while `ram_wr_en` = 1; high-Z otherwise.

## Operation

- **RAM contract**
  - RAM writes `data` to `mem[addr]` on a rising edge where `wr_en` = 1.
  - While `wr_en` = 0, RAM drives `mem[addr]` onto `data` combinationally.
- **States:** IDLE, WRITE, READ.
- **IDLE**
  - If any `req` is high, select a port and assert its `gnt` for that cycle. `gnt` is combinational from `req`, state and the pointer.
  - On the clock edge, capture the selected port's `we`, `addr`, `wdata` and id into command registers.
  - Go to WRITE if `we` = 1, else READ.
  - No `gnt` is asserted in WRITE or READ.
- **WRITE** (one cycle)
  - `ram_addr` = captured address; `ram_wr_en` = 1; `ram_data` = captured wdata.
  - RAM stores the word on the closing edge. Return to IDLE.
- **READ** (one cycle)
  - `ram_addr` = captured address; `ram_wr_en` = 0; bus released.
  - On the closing edge, sample `ram_data` into the owning port's `rdata` and set its `rvalid` for the next cycle. Return to IDLE.
- **Arbitration**
  - `last` pointer holds the most recently granted port.
  - Both requesting: grant the port ≠ `last`.
  - One requesting: grant it regardless of `last`.
  - `last` updates only on a grant.
- **Output registers:** `ram_wr_en`, `ram_addr` and the bus-drive enable are registered. Drive enable and `ram_wr_en` come from one flop, so there is no contention window.
- **Hold behaviour:** in IDLE, `ram_addr` holds its last value and `ram_wr_en` = 0.
- **Ordering:** write followed by read to the same address returns the new data. Commands complete strictly in grant order.

## Timing

- **Reset values** (`rst_n` low at a rising edge):
  - state = IDLE, `last` = 1 (port 0 wins first contention).
  - `ram_wr_en` = 0, `ram_addr` = 0, `ram_data` = Z.
  - Both `rvalid` = 0, both `rdata` = 0.
  - `gnt` = 0 while `rst_n` is low.
- **Write latency:** `gnt` in cycle N; `ram_wr_en` high in cycle N+1; data in RAM after the edge ending N+1.
- **Read latency:** `gnt` in cycle N; address on bus in N+1; `rvalid` and `rdata` valid in N+2.
- **Throughput:** at most one command per 2 cycles. Next `gnt` earliest in N+2. A read's `rvalid` cycle can coincide with the next `gnt`.
- **Reset mid-operation**
  - Reset sampled while in WRITE: the RAM still stores on that edge, because `wr_en` was already 1.
  - Reset sampled while in READ: `rvalid` is not asserted and `rdata` is cleared.
  - In both cases the next state is IDLE.
- **`req` dropped before `gnt`:** legal; nothing is captured.
- **Address range:** all `2**ADDR_WIDTH` addresses are valid; no wrap or range check.

## Test plan

- **Reset:** hold `rst_n` low 3 cycles with both `req` = 1 → `gnt`, `rvalid`, `rdata`, `ram_addr`, `ram_wr_en` all 0; `ram_data` = Z; no RAM writes.
- **Single port write/read:** p0 writes addr 3, data 16'hA5A5, then reads addr 3 → `p0_gnt` on each request cycle; `ram_wr_en` high exactly 1 cycle; `p0_rvalid` 2 cycles after the read `gnt`; `p0_rdata` = 16'hA5A5.
- **Contention:** both ports request writes continuously (p0 to addr 0..7, p1 to addr 8..15) → grants alternate p0, p1, p0, … starting with p0, one every 2 cycles; all 16 RAM words match the written values.
- **Single requester, no starvation penalty:** only p1 requests, 4 back-to-back reads → `p1_gnt` every 2 cycles; `p0_rvalid` stays 0; `p1_rdata` matches RAM contents.
- **Reset mid-read:** assert `rst_n` low during a READ cycle → no `rvalid`, `rdata` = 0, state IDLE; the following p0 request is granted and completes normally.
- **Bus ownership:** across all scenarios, `ram_data` is never X; it is non-Z from the arbiter only when `ram_wr_en` = 1.
